mdu_unit: RTL

//   Multi-cycle multiply/divide unit in the E stage, with HI/LO registers.
//   It drives MDU_Start and MDU_Busy, which the hazard/stall logic reads.

---
 rtl/mdu_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage, holding the HI/LO registers.
// A mult/div result is computed at issue, then written to HI/LO after the configured busy period.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        MDU_Start,
  output logic        MDU_Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      hi_q, lo_q, hi_next, lo_next;
  logic [31:0]      tmp_hi, tmp_lo, tmp_hi_next, tmp_lo_next;
  logic             tmp_ok, tmp_ok_next;
  state_t           state;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] dividend, divisor, divisor_safe, q_mag, r_mag, quot, rem;

  assign state     = (cnt != '0) ? RUN : IDLE;
  assign MDU_Busy  = (state == RUN);
  assign MDU_Start = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU) && !MDU_Busy;
  assign HI        = hi_q;
  assign LO        = lo_q;

  // Signed product falls out of the low 64 bits of a sign-extended product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
  assign div_signed   = (MDUOp == OP_DIV);
  assign a_neg        = div_signed && A[31];
  assign b_neg        = div_signed && B[31];
  assign dividend     = a_neg ? (32'd0 - A) : A;
  assign divisor      = b_neg ? (32'd0 - B) : B;
  assign divisor_safe = (divisor == 32'd0) ? 32'd1 : divisor;
  assign q_mag        = dividend / divisor_safe;
  assign r_mag        = dividend % divisor_safe;
  assign quot         = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem          = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    cnt_next    = cnt;
    hi_next     = hi_q;
    lo_next     = lo_q;
    tmp_hi_next = tmp_hi;
    tmp_lo_next = tmp_lo;
    tmp_ok_next = tmp_ok;
    if (state == IDLE) begin
      if (MDU_Start) begin
        tmp_ok_next = 1'b1;
        if (MDUOp == OP_MULT) begin
          {tmp_hi_next, tmp_lo_next} = prod_s;
          cnt_next = CNT_W'(MULT_CYCLES);
        end else if (MDUOp == OP_MULTU) begin
          {tmp_hi_next, tmp_lo_next} = prod_u;
          cnt_next = CNT_W'(MULT_CYCLES);
        end else begin
          tmp_hi_next = rem;
          tmp_lo_next = quot;
          tmp_ok_next = (B != 32'd0);
          cnt_next    = CNT_W'(DIV_CYCLES);
        end
      end else if (MDUOp == OP_MTHI) begin
        hi_next = A;
      end else if (MDUOp == OP_MTLO) begin
        lo_next = A;
      end
    end else begin
      // Requests arriving in RUN are ignored; only the countdown advances.
      cnt_next = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && tmp_ok) begin
        hi_next = tmp_hi;
        lo_next = tmp_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      tmp_ok <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      hi_q   <= hi_next;
      lo_q   <= lo_next;
      tmp_hi <= tmp_hi_next;
      tmp_lo <= tmp_lo_next;
      tmp_ok <= tmp_ok_next;
    end
  end

  always_comb begin
    MDU_Out = 32'd0;
    if (MDUOp == OP_MFHI)
      MDU_Out = hi_q;
    else if (MDUOp == OP_MFLO)
      MDU_Out = lo_q;
  end

endmodule
